mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; also the multiply/divide iteration count.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only while idle.
REQ-005 op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 a, b  input  WIDTH each  multiplicand/dividend (a), multiplier/divisor (b), sampled with start.
REQ-007 kill  input  1  abort in-flight operation (pipeline flush).
REQ-008 busy  output  1  operation in progress; the core stalls MFHI/MFLO/MULT/DIV while high.
REQ-009 done  output  1  one-cycle pulse: hi/lo/err updated.
REQ-010 hi, lo  output  WIDTH each  HI/LO architectural registers.
REQ-011 err  output  1  last operation was divide-by-zero or an unsupported op; valid with done, held until next done.

Function
REQ-012 States: IDLE, RUN; busy = (state == RUN).
REQ-013 IDLE with start=1 and kill=0 at edge of cycle k: latch operands, enter RUN, iteration counter = 0.
REQ-014 RUN lasts exactly WIDTH cycles (k+1..k+WIDTH), one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
REQ-015 At end of cycle k+WIDTH: write hi/lo, return to IDLE; done=1 and busy=0 in cycle k+WIDTH+1.
REQ-016 A start in the done cycle is accepted (back-to-back issue, no bubble).
REQ-017 Multiply: {hi,lo} = full 2*WIDTH-bit product; err=0.
REQ-018 Divide: lo = quotient, hi = remainder; err=0.
REQ-019 Signed ops: magnitudes taken at accept; quotient truncates toward zero; remainder takes sign of dividend; product sign = a XOR b sign; most-negative operand handled without overflow of the internal 2*WIDTH datapath.
REQ-020 Divide with b=0: no RUN; done and err=1 in cycle k+1; hi = a, lo = all ones; busy never asserted.
REQ-021 start while busy is ignored; operands are not re-sampled.
REQ-022 kill in RUN: return to IDLE at that edge; hi/lo/err unchanged; no done pulse; busy=0 next cycle.
REQ-023 kill and start together in IDLE: kill wins, request dropped.
REQ-024 hi/lo change only on done or reset.

Reset
REQ-025 rst_n low: state=IDLE, counter=0, busy=0, done=0, err=0, hi=0, lo=0, immediately without clock.
REQ-026 Reset during RUN discards the operation; no done after release.
REQ-027 First start is honoured on the first rising edge with rst_n high.

Configuration
REQ-028 Macro MDU_DIV_EN: defined -> divide ops per REQ-018..REQ-020.
REQ-029 MDU_DIV_EN undefined -> divider logic absent; op 10/11 complete as in REQ-020 timing (done+err in cycle k+1) but hi/lo unchanged; multiply unaffected.

Structure
REQ-030 Shared package holds op encoding constants (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV) and the state enum, reused by decoder and hazard unit.
REQ-031 One sub-module, mdu_iter: single combinational multiply/divide step (partial remainder/product in, next value out); mdu_ctrl owns all state and registers.

Verification
REQ-032 MULTU a=200,b=3, start in cycle 0 -> busy cycles 1..8, done cycle 9, hi=0x02, lo=0x58, err=0.
REQ-033 MULT a=0xFD(-3),b=5 -> hi=0xFF, lo=0xF1; then DIV a=0xF9(-7),b=2 issued in done cycle -> lo=0xFD, hi=0xFF, done cycle 18.
REQ-034 DIVU a=200,b=7 -> lo=0x1C, hi=0x04; DIVU a=9,b=0 -> done cycle 1, err=1, hi=0x09, lo=0xFF, busy never high.
REQ-035 MULTU 5*5 after prior hi/lo=0x1234, kill in cycle 4 -> busy low cycle 5, no done, hi/lo stay 0x12/0x34; start during busy ignored.
REQ-036 rst_n low mid-RUN at cycle 3 -> all outputs 0 immediately, no done after release; with MDU_DIV_EN undefined, DIVU 8/2 -> done+err cycle 1, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide unit definitions: op encodings and controller states,
// also imported by the decoder and hazard unit.
package mdu_ctrl_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// One combinational step of the iterative unit: shift-add multiply or restoring
// shift-subtract divide on a {upper, lower} accumulator. Divide path needs MDU_DIV_EN.
module mdu_iter #(
    parameter int WIDTH = 8
) (
`ifdef MDU_DIV_EN
    input  logic               is_div,
`endif
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH:0]   acc_nxt
);

    // Multiply: low half holds the remaining multiplier bits, LSB first.
    logic [WIDTH:0]   msum;
    logic [2*WIDTH:0] mnext;

    assign msum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    assign mnext = {1'b0, msum, acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    // Divide: the partial remainder can reach WIDTH+1 bits after the shift, so the
    // trial subtraction is one bit wider to get a clean borrow.
    logic [2*WIDTH:0] sh;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH:0] dnext;

    assign sh    = {acc[2*WIDTH-1:0], 1'b0};
    assign diff  = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, opnd};
    assign dnext = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};

    assign acc_nxt = is_div ? dnext : mnext;
`else
    assign acc_nxt = mnext;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller owning the HI/LO registers.
// Divide ops are implemented only when MDU_DIV_EN is defined; otherwise they flag err.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH + 1;

    mdu_state_e         state;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic               neg_lo;
    logic               is_mul_op;
    logic               is_div_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_mul_op = (op == MDU_MULTU) || (op == MDU_MULT);
    assign is_div_op = (op == MDU_DIVU) || (op == MDU_DIV);
    assign a_neg     = ((op == MDU_MULT) || (op == MDU_DIV)) && a[WIDTH-1];
    assign b_neg     = ((op == MDU_MULT) || (op == MDU_DIV)) && b[WIDTH-1];
    // Magnitudes are unsigned WIDTH-bit, so the most-negative value maps to 2^(WIDTH-1).
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
    assign prod_fix  = neg_lo ? (~acc_nxt[2*WIDTH-1:0] + 1'b1) : acc_nxt[2*WIDTH-1:0];
    assign busy      = (state == ST_RUN);

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_hi;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign quot_fix = neg_lo ? (~acc_nxt[WIDTH-1:0] + 1'b1) : acc_nxt[WIDTH-1:0];
    assign rem_fix  = neg_hi ? (~acc_nxt[2*WIDTH-1:WIDTH] + 1'b1) : acc_nxt[2*WIDTH-1:WIDTH];
`endif

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
`ifdef MDU_DIV_EN
        .is_div  (is_div),
`endif
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !kill) begin
                        if (is_mul_op) begin
                            state  <= ST_RUN;
                            cnt    <= '0;
                            acc    <= {{(WIDTH+1){1'b0}}, b_mag};
                            opnd   <= a_mag;
                            neg_lo <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                            is_div <= 1'b0;
                            neg_hi <= 1'b0;
`endif
                        end
`ifdef MDU_DIV_EN
                        else if (b == '0) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                            hi   <= a;
                            lo   <= '1;
                        end else begin
                            state  <= ST_RUN;
                            cnt    <= '0;
                            acc    <= {{(WIDTH+1){1'b0}}, a_mag};
                            opnd   <= b_mag;
                            is_div <= 1'b1;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                        end
`else
                        else if (is_div_op) begin
                            // No divider: complete immediately, flag it, keep HI/LO.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            err   <= 1'b0;
`ifdef MDU_DIV_EN
                            if (is_div) begin
                                hi <= rem_fix;
                                lo <= quot_fix;
                            end else begin
                                {hi, lo} <= prod_fix;
                            end
`else
                            {hi, lo} <= prod_fix;
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (WIDTH=8); divide expectations follow MDU_DIV_EN.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         kill  = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an iterating op; optionally pulse a bogus start at busy cycle 'poke'.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int poke);
        start = 1'b1; op = o; a = ia; b = ib;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == poke) begin
                start = 1'b1; op = MDU_MULTU; a = 8'h01; b = 8'h01;
            end
            check({tag, "_run"}, 32'({busy, done}), 32'(2'b10));
            tick();
            start = 1'b0;
        end
        check({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
        check({tag, "_err"}, 32'(err), 32'(1'b0));
        check({tag, "_hi"}, 32'(hi), 32'(eh));
        check({tag, "_lo"}, 32'(lo), 32'(el));
    endtask

    // Issue an op that must finish in the next cycle with err set and no busy.
    task automatic run_quick(input string tag, input logic [1:0] o, input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input logic [W-1:0] eh,
                             input logic [W-1:0] el);
        start = 1'b1; op = o; a = ia; b = ib;
        tick();
        start = 1'b0;
        check({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
        check({tag, "_err"}, 32'(err), 32'(1'b1));
        check({tag, "_hi"}, 32'(hi), 32'(eh));
        check({tag, "_lo"}, 32'(lo), 32'(el));
    endtask

    initial begin
        // Reset state, before any clock edge.
        #2;
        check("reset_outs", 32'({busy, done, err, hi, lo}), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // First start right after release; bogus start while busy is ignored.
        run_op("multu_200x3", MDU_MULTU, 8'd200, 8'd3, 8'h02, 8'h58, 2);
        // Back-to-back issue in done cycles.
        run_op("mult_m3x5", MDU_MULT, 8'hFD, 8'h05, 8'hFF, 8'hF1, -1);
`ifdef MDU_DIV_EN
        run_op("div_m7d2", MDU_DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD, -1);
        run_op("divu_200d7", MDU_DIVU, 8'd200, 8'd7, 8'h04, 8'h1C, -1);
        run_quick("divu_9d0", MDU_DIVU, 8'd9, 8'd0, 8'h09, 8'hFF);
`else
        run_quick("div_m7d2", MDU_DIV, 8'hF9, 8'h02, 8'hFF, 8'hF1);
        run_quick("divu_200d7", MDU_DIVU, 8'd200, 8'd7, 8'hFF, 8'hF1);
        run_quick("divu_9d0", MDU_DIVU, 8'd9, 8'd0, 8'hFF, 8'hF1);
`endif
        tick();
        check("err_held", 32'({busy, done, err}), 32'(3'b001));

        // Kill mid-run: no done, HI/LO hold the previous result.
        run_op("multu_1234", MDU_MULTU, 8'hE9, 8'h14, 8'h12, 8'h34, -1);
        start = 1'b1; op = MDU_MULTU; a = 8'd5; b = 8'd5;
        tick();
        start = 1'b0;
        check("kill_busy1", 32'(busy), 32'(1'b1));
        tick();
        start = 1'b1; a = 8'h01; b = 8'h01;
        tick();
        start = 1'b0;
        check("kill_busy3", 32'(busy), 32'(1'b1));
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_idle", 32'({busy, done}), 32'(2'b00));
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("kill_nodone", 32'({busy, done, hi, lo}), 32'({2'b00, 16'h1234}));
        end

        // Kill and start together in idle: request dropped.
        start = 1'b1; kill = 1'b1; op = MDU_MULTU; a = 8'd7; b = 8'd7;
        tick();
        start = 1'b0; kill = 1'b0;
        check("killstart_c1", 32'({busy, done}), 32'(2'b00));
        tick();
        check("killstart_c2", 32'({busy, done, hi, lo}), 32'({2'b00, 16'h1234}));

        // Most-negative operands.
        run_op("mult_min", MDU_MULT, 8'h80, 8'h80, 8'h40, 8'h00, -1);
`ifdef MDU_DIV_EN
        run_op("div_min", MDU_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, -1);
`endif

        // Asynchronous reset mid-run.
        start = 1'b1; op = MDU_MULTU; a = 8'd5; b = 8'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({busy, done, err, hi, lo}), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            check("rst_nodone", 32'({busy, done}), 32'(2'b00));
            tick();
        end
`ifdef MDU_DIV_EN
        run_op("divu_8d2", MDU_DIVU, 8'd8, 8'd2, 8'h00, 8'h04, -1);
`else
        run_quick("divu_8d2", MDU_DIVU, 8'd8, 8'd2, 8'h00, 8'h00);
`endif
        tick();
        check("final_idle", 32'({busy, done}), 32'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
